dual_fetch_queue: RTL and testbench

Front-end fetch sequencer and instruction queue for the dual-issue pipeline. It is the consumer of the hazard unit's fetch/decode stall and branch-redirect outputs. It issues aligned two-instruction fetch requests to a synchronous instruction memory and buffers returned pairs in a small FIFO. Each cycle it presents one pair to decode, flushing and redirecting when either lane resolves a taken branch or jump in execute.

---
 rtl/dual_fetch_queue_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/dual_fetch_queue.sv | 139 +++++++++++++
 tb/tb_dual_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_fetch_queue_pkg.sv
// Shared types for the dual-issue fetch front end: queue entry layout,
// sequencer states and the fetch stride.
package dual_fetch_queue_pkg;

    localparam logic [31:0] FETCH_STRIDE = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic        v1;
        logic        v2;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetchq_state_e;

    function automatic logic [31:0] align_fetch(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with explicit count; head is read
// combinationally and forced to zero while the buffer is empty.
module fetch_fifo
    import dual_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ENTRY_W-1:0]       head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A full buffer only accepts a write when the head leaves in the same cycle.
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (clear) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem[rd_q] : '0;

endmodule

// File: rtl/dual_fetch_queue.sv
// Fetch sequencer: issues aligned pair fetches, queues returned pairs and
// flushes/redirects on a taken branch from either execute lane.
module dual_fetch_queue
    import dual_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   StallFetch1,
    input  logic                   StallFetch2,
    input  logic                   StallDecode1,
    input  logic                   StallDecode2,
    input  logic                   BranchIn1,
    input  logic                   BranchIn2,
    input  logic [31:0]            PCTargetE1,
    input  logic [31:0]            PCTargetE2,
    input  logic [31:0]            InstrF1,
    input  logic [31:0]            InstrF2,
    output logic [31:0]            PCF,
    output logic                   FetchReqF,
    output logic [31:0]            InstrD1,
    output logic [31:0]            InstrD2,
    output logic [31:0]            PCD1,
    output logic [31:0]            PCD2,
    output logic                   ValidD1,
    output logic                   ValidD2,
    output logic [$clog2(DEPTH):0] QueueCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetchq_state_e state_q, state_d;
    logic [31:0]   pcf_q, pcf_d, req_pc_q, req_pc_d;
    logic          skip_q, skip_d, req_skip_q, req_skip_d, inflight_q, inflight_d;
    logic          fetch_en, redirect, issue, push, pop, has_head;
    logic [31:0]   target;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry, head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_en = 1'b0;
        case (state_q)
            RUN:     fetch_en = 1'b1;
            default: fetch_en = 1'b0;
        endcase
    end

    // Lane 1 is the older instruction, so its redirect wins.
    assign redirect  = BranchIn1 | BranchIn2;
    assign target    = BranchIn1 ? PCTargetE1 : PCTargetE2;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue     = fetch_en && !(StallFetch1 | StallFetch2) && !redirect
                       && (occupancy < (CW + 1)'(DEPTH));
    assign push      = inflight_q && !redirect;
    assign has_head  = (count != '0);
    assign pop       = !redirect && has_head && !(StallDecode1 | StallDecode2);

    always_comb begin
        pcf_d      = pcf_q;
        skip_d     = skip_q;
        req_pc_d   = req_pc_q;
        req_skip_d = req_skip_q;
        inflight_d = issue;
        if (redirect) begin
            pcf_d  = align_fetch(target);
            skip_d = target[2];
        end else if (issue) begin
            req_pc_d   = pcf_q;
            req_skip_d = skip_q;
            skip_d     = 1'b0;
            pcf_d      = pcf_q + FETCH_STRIDE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q      <= RESET_PC;
            skip_q     <= 1'b0;
            req_pc_q   <= '0;
            req_skip_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            skip_q     <= skip_d;
            req_pc_q   <= req_pc_d;
            req_skip_q <= req_skip_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        push_entry.pc     = req_pc_q;
        push_entry.instr1 = InstrF1;
        push_entry.instr2 = InstrF2;
        push_entry.v1     = !req_skip_q;
        push_entry.v2     = 1'b1;
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );

    assign FetchReqF  = issue;
    assign PCF        = pcf_q;
    assign QueueCount = count;
    assign InstrD1    = head.instr1;
    assign InstrD2    = head.instr2;
    assign PCD1       = head.pc;
    assign PCD2       = has_head ? head.pc + 32'd4 : '0;
    assign ValidD1    = head.v1;
    assign ValidD2    = head.v2;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Bench for dual_fetch_queue: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_dual_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallFetch1, StallFetch2, StallDecode1, StallDecode2;
    logic        BranchIn1, BranchIn2;
    logic [31:0] PCTargetE1, PCTargetE2;
    logic [31:0] InstrF1, InstrF2;
    logic [31:0] PCF, InstrD1, InstrD2, PCD1, PCD2;
    logic        FetchReqF, ValidD1, ValidD2;
    logic [$clog2(DEPTH):0] QueueCount;

    dual_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .StallFetch1(StallFetch1), .StallFetch2(StallFetch2),
        .StallDecode1(StallDecode1), .StallDecode2(StallDecode2),
        .BranchIn1(BranchIn1), .BranchIn2(BranchIn2),
        .PCTargetE1(PCTargetE1), .PCTargetE2(PCTargetE2),
        .InstrF1(InstrF1), .InstrF2(InstrF2),
        .PCF(PCF), .FetchReqF(FetchReqF),
        .InstrD1(InstrD1), .InstrD2(InstrD2),
        .PCD1(PCD1), .PCD2(PCD2),
        .ValidD1(ValidD1), .ValidD2(ValidD2),
        .QueueCount(QueueCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous instruction memory: answers the address presented last cycle.
    logic [31:0] mem_pc = 32'h0;
    always @(posedge clk) mem_pc <= PCF;
    assign InstrF1 = word_at(mem_pc);
    assign InstrF2 = word_at(mem_pc + 32'd4);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        v1;
        logic        v2;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pcf, m_req_pc;
    bit          m_skip, m_req_skip, m_infl, m_boot;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pcf      = RESET_PC;
        m_req_pc   = 32'h0;
        m_skip     = 1'b0;
        m_req_skip = 1'b0;
        m_infl     = 1'b0;
        m_boot     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pcf"},   PCF, RESET_PC);
        chk({tag, "_req"},   32'(FetchReqF), 32'h0);
        chk({tag, "_count"}, 32'(QueueCount), 32'h0);
        chk({tag, "_v1"},    32'(ValidD1), 32'h0);
        chk({tag, "_v2"},    32'(ValidD2), 32'h0);
        chk({tag, "_pcd1"},  PCD1, 32'h0);
        chk({tag, "_pcd2"},  PCD2, 32'h0);
        chk({tag, "_i1"},    InstrD1, 32'h0);
        chk({tag, "_i2"},    InstrD2, 32'h0);
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit          redir, exp_issue, stall_d;
        logic [31:0] tgt;
        ent_t        e;
        @(negedge clk);
        redir     = BranchIn1 || BranchIn2;
        tgt       = BranchIn1 ? PCTargetE1 : PCTargetE2;
        stall_d   = StallDecode1 || StallDecode2;
        exp_issue = !m_boot && !(StallFetch1 || StallFetch2) && !redir
                    && (mq.size() + int'(m_infl) < DEPTH);
        chk("fetchreq", 32'(FetchReqF), 32'(exp_issue));
        chk("pcf", PCF, m_pcf);
        chk("count", 32'(QueueCount), 32'(mq.size()));
        if (mq.size() > 0) begin
            chk("validd1", 32'(ValidD1), 32'(mq[0].v1));
            chk("validd2", 32'(ValidD2), 32'(mq[0].v2));
            chk("pcd1", PCD1, mq[0].pc);
            chk("pcd2", PCD2, mq[0].pc + 32'd4);
            chk("instrd1", InstrD1, mq[0].i1);
            chk("instrd2", InstrD2, mq[0].i2);
        end else begin
            chk("validd1_empty", 32'(ValidD1), 32'h0);
            chk("validd2_empty", 32'(ValidD2), 32'h0);
        end
        @(posedge clk);
        if (redir) begin
            mq.delete();
            m_pcf  = {tgt[31:3], 3'b000};
            m_skip = tgt[2];
            m_infl = 1'b0;
        end else begin
            if (mq.size() > 0 && !stall_d) void'(mq.pop_front());
            if (m_infl) begin
                e.pc = m_req_pc;
                e.i1 = word_at(m_req_pc);
                e.i2 = word_at(m_req_pc + 32'd4);
                e.v1 = !m_req_skip;
                e.v2 = 1'b1;
                mq.push_back(e);
            end
            if (exp_issue) begin
                m_req_pc   = m_pcf;
                m_req_skip = m_skip;
                m_skip     = 1'b0;
                m_pcf      = m_pcf + 32'd8;
            end
            m_infl = exp_issue;
        end
        m_boot = 1'b0;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        StallFetch1 = 0; StallFetch2 = 0; StallDecode1 = 0; StallDecode2 = 0;
        BranchIn1 = 0; BranchIn2 = 0; PCTargetE1 = 0; PCTargetE2 = 0;
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold start streaming.
        run(8);

        // Decode stall fills the queue; no entry lost.
        StallDecode1 = 1; run(6);
        StallDecode1 = 0; run(6);

        // Build three queued entries, then lane-2 redirect.
        StallDecode1 = 1;
        for (int i = 0; i < 20; i++) begin
            if (QueueCount == 3) break;
            step();
        end
        chk("fill3_count", 32'(QueueCount), 32'd3);
        StallDecode1 = 0;
        BranchIn2 = 1; PCTargetE2 = 32'h100; step();
        BranchIn2 = 0; run(5);

        // Both lanes redirect: lane 1 wins, lane-1 slot skipped.
        BranchIn1 = 1; PCTargetE1 = 32'h204; BranchIn2 = 1; PCTargetE2 = 32'h300; step();
        BranchIn1 = 0; BranchIn2 = 0; run(2);
        chk("dual_pcd1", PCD1, 32'h200);
        chk("dual_v1", 32'(ValidD1), 32'h0);
        chk("dual_pcd2", PCD2, 32'h204);
        chk("dual_v2", 32'(ValidD2), 32'h1);
        run(3);

        // Fetch stall: queue drains, PCF frozen.
        StallFetch1 = 1; run(3);
        StallFetch1 = 0; run(4);

        // Redirect while both stalls are held, including wrap-around target.
        StallFetch2 = 1; StallDecode2 = 1;
        BranchIn1 = 1; PCTargetE1 = 32'hFFFF_FFFC; step();
        BranchIn1 = 0; run(2);
        StallFetch2 = 0; StallDecode2 = 0; run(6);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            StallFetch1  = ($urandom_range(0, 7) == 0);
            StallFetch2  = ($urandom_range(0, 9) == 0);
            StallDecode1 = ($urandom_range(0, 3) == 0);
            StallDecode2 = ($urandom_range(0, 5) == 0);
            BranchIn1    = ($urandom_range(0, 15) == 0);
            BranchIn2    = ($urandom_range(0, 11) == 0);
            PCTargetE1   = $urandom();
            PCTargetE2   = $urandom();
            step();
        end
        StallFetch1 = 0; StallFetch2 = 0; StallDecode1 = 0; StallDecode2 = 0;
        BranchIn1 = 0; BranchIn2 = 0;
        run(4);

        // Asynchronous reset with a request in flight; the stale response is dropped.
        chk("pre_reset_req", 32'(FetchReqF), 32'h1);
        step();
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        #1;
        rst = 1'b0;
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
